eu_arithmetic: RTL and testbench

//  Arithmetic half of the execution-unit ALU. Selects one of eight adder

---
 rtl/eu_arithmetic.sv | 137 +++++++++++++
 tb/tb_eu_arithmetic.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eu_arithmetic.sv
// Arithmetic half of the execution-unit ALU: one adder shared by eight
// micro-operations, with the result and status flags registered together.
module eu_arithmetic #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  input  logic [3:0]           op_select,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 zero,
  output logic                 carry,
  output logic                 overflow,
  output logic                 negative
);

  typedef enum logic [2:0] {
    OP_MOVA  = 3'b000,
    OP_INC   = 3'b001,
    OP_ADD   = 3'b010,
    OP_ADDC  = 3'b011,
    OP_ADD1C = 3'b100,
    OP_SUB   = 3'b101,
    OP_DEC   = 3'b110,
    OP_TRA   = 3'b111
  } arith_op_e;

  arith_op_e            op_s;
  logic [BUS_WIDTH-1:0] y_s;
  logic                 cin_s;
  logic [BUS_WIDTH:0]   sum_s;
  logic [BUS_WIDTH-1:0] low_sum_s;
  logic                 msb_cin_s;
  logic                 overflow_s;
  logic                 zero_s;

  logic [BUS_WIDTH-1:0] data_r;
  logic                 zero_r;
  logic                 carry_r;
  logic                 overflow_r;
  logic                 negative_r;

  assign op_s = arith_op_e'(op_select[2:0]);

  // Decode the micro-operation into the adder's second operand and carry-in.
  always_comb begin
    y_s   = {BUS_WIDTH{1'b0}};
    cin_s = 1'b0;
    if (op_select[3]) begin
      // Reserved encodings behave as MOVA.
      y_s   = {BUS_WIDTH{1'b0}};
      cin_s = 1'b0;
    end else begin
      case (op_s)
        OP_MOVA: begin
          y_s   = {BUS_WIDTH{1'b0}};
          cin_s = 1'b0;
        end
        OP_INC: begin
          y_s   = {BUS_WIDTH{1'b0}};
          cin_s = 1'b1;
        end
        OP_ADD: begin
          y_s   = B;
          cin_s = 1'b0;
        end
        OP_ADDC: begin
          y_s   = B;
          cin_s = 1'b1;
        end
        OP_ADD1C: begin
          y_s   = ~B;
          cin_s = 1'b0;
        end
        OP_SUB: begin
          y_s   = ~B;
          cin_s = 1'b1;
        end
        OP_DEC: begin
          y_s   = {BUS_WIDTH{1'b1}};
          cin_s = 1'b0;
        end
        OP_TRA: begin
          y_s   = {BUS_WIDTH{1'b0}};
          cin_s = 1'b0;
        end
        default: begin
          y_s   = {BUS_WIDTH{1'b0}};
          cin_s = 1'b0;
        end
      endcase
    end
  end

  // Full-width sum plus the sum of the bits below the MSB, whose top bit is
  // the carry into the MSB used for signed overflow detection.
  always_comb begin
    sum_s      = {1'b0, A} + {1'b0, y_s} + {{BUS_WIDTH{1'b0}}, cin_s};
    low_sum_s  = {1'b0, A[BUS_WIDTH-2:0]} + {1'b0, y_s[BUS_WIDTH-2:0]}
               + {{(BUS_WIDTH-1){1'b0}}, cin_s};
    msb_cin_s  = low_sum_s[BUS_WIDTH-1];
    overflow_s = msb_cin_s ^ sum_s[BUS_WIDTH];
    zero_s     = (sum_s[BUS_WIDTH-1:0] == {BUS_WIDTH{1'b0}});
  end

  // Result and flag registers; all five update together on an enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {BUS_WIDTH{1'b0}};
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      negative_r <= 1'b0;
    end else if (en) begin
      data_r     <= sum_s[BUS_WIDTH-1:0];
      zero_r     <= zero_s;
      carry_r    <= sum_s[BUS_WIDTH];
      overflow_r <= overflow_s;
      negative_r <= sum_s[BUS_WIDTH-1];
    end else begin
      data_r     <= data_r;
      zero_r     <= zero_r;
      carry_r    <= carry_r;
      overflow_r <= overflow_r;
      negative_r <= negative_r;
    end
  end

  assign data_out = data_r;
  assign zero     = zero_r;
  assign carry    = carry_r;
  assign overflow = overflow_r;
  assign negative = negative_r;

endmodule

// File: tb/tb_eu_arithmetic.sv
// Self-checking bench for eu_arithmetic: directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_eu_arithmetic;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  op_select;
  logic [15:0] data_out;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        negative;

  int err_cnt;
  int chk_cnt;

  // Expected register state kept by the bench.
  logic [15:0] exp_data;
  logic        exp_z, exp_c, exp_v, exp_n;

  eu_arithmetic #(.BUS_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .A         (A),
    .B         (B),
    .op_select (op_select),
    .data_out  (data_out),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"}, 32'(data_out), 32'(exp_data));
    check({tag, ".zero"}, 32'(zero), 32'(exp_z));
    check({tag, ".carry"}, 32'(carry), 32'(exp_c));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_v));
    check({tag, ".neg"}, 32'(negative), 32'(exp_n));
  endtask

  // Reference: unsigned sum gives result and carry, signed sum gives overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int ua, uy, sa, sy, cin, f, sf;
    ua  = int'(a);
    sa  = int'($signed(a));
    uy  = 0;
    sy  = 0;
    cin = 0;
    if (op[3] == 1'b0) begin
      case (op[2:0])
        3'd1: cin = 1;
        3'd2: begin uy = int'(b); sy = int'($signed(b)); end
        3'd3: begin uy = int'(b); sy = int'($signed(b)); cin = 1; end
        3'd4: begin uy = 65535 - int'(b); sy = -int'($signed(b)) - 1; end
        3'd5: begin uy = 65535 - int'(b); sy = -int'($signed(b)) - 1; cin = 1; end
        3'd6: begin uy = 65535; sy = -1; end
        default: begin uy = 0; sy = 0; end
      endcase
    end
    f  = ua + uy + cin;
    sf = sa + sy + cin;
    exp_data = f[15:0];
    exp_c    = (f >= 65536);
    exp_v    = (sf > 32767) || (sf < -32768);
    exp_z    = (exp_data == 16'h0000);
    exp_n    = exp_data[15];
  endtask

  // Drive one cycle of inputs, update the model, then check after the edge.
  task automatic step(input string tag, input logic e, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] op);
    @(negedge clk);
    en        = e;
    A         = a;
    B         = b;
    op_select = op;
    @(posedge clk);
    #1;
    if (e) model(a, b, op);
    check_outputs(tag);
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    A         = 16'h0000;
    B         = 16'h0000;
    op_select = 4'h0;
    exp_data  = 16'h0000;
    exp_z     = 1'b0;
    exp_c     = 1'b0;
    exp_v     = 1'b0;
    exp_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero state, then reset mid-cycle and expect immediate clear.
    step("pre_rst", 1'b1, 16'hFFFF, 16'h0000, 4'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_data = 16'h0000; exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0; exp_n = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    step("first",   1'b1, 16'h0000, 16'h0000, 4'h0);
    check("first.zero_const", 32'(zero), 32'd1);
    step("mova",    1'b1, 16'h0001, 16'h0000, 4'h0);
    step("inc",     1'b1, 16'h00FF, 16'h0000, 4'h1);
    step("inc_ovf", 1'b1, 16'h7FFF, 16'h0000, 4'h1);
    check("inc_ovf.data_const", 32'(data_out), 32'h8000);
    check("inc_ovf.ovf_const", 32'(overflow), 32'd1);
    step("add",     1'b1, 16'h00FF, 16'h0000, 4'h2);
    step("add_wrap",1'b1, 16'hFFF1, 16'h000F, 4'h2);
    check("add_wrap.carry_const", 32'(carry), 32'd1);
    step("sub",     1'b1, 16'h00FF, 16'h000F, 4'h5);
    step("sub_brw", 1'b1, 16'h0000, 16'h0001, 4'h5);
    check("sub_brw.data_const", 32'(data_out), 32'hFFFF);
    check("sub_brw.carry_const", 32'(carry), 32'd0);
    step("sub_ovf", 1'b1, 16'h8000, 16'h0001, 4'h5);
    check("sub_ovf.data_const", 32'(data_out), 32'h7FFF);
    check("sub_ovf.ovf_const", 32'(overflow), 32'd1);
    step("dec",     1'b1, 16'h0001, 16'h0000, 4'h6);
    step("dec_wrap",1'b1, 16'h0000, 16'h0000, 4'h6);
    step("addc",    1'b1, 16'h1234, 16'h1111, 4'h3);
    step("add1c",   1'b1, 16'h0005, 16'h0003, 4'h4);
    step("tra",     1'b1, 16'hABCD, 16'h5555, 4'h7);
    step("hold1",   1'b0, 16'h5A5A, 16'h1234, 4'h2);
    step("hold2",   1'b0, 16'h0000, 16'hFFFF, 4'h5);
    step("rsvd",    1'b1, 16'h1234, 16'hFFFF, 4'hD);
    check("rsvd.data_const", 32'(data_out), 32'h1234);
    step("rsvd_f",  1'b1, 16'hFFFF, 16'hFFFF, 4'hF);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      logic        re;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      re  = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        default: ;
      endcase
      step("rand", re, ra, rb, rop);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
